alu_pipe: RTL and testbench

- Parametrised successor to the team's combinational 4-bit ALU.
- N-bit ALU with registered output, valid/ready handshakes on input and output, and a status flag vector.
- Adds a multi-cycle shift-add multiplier.
- Sits between the instruction decoder (upstream) and the register writeback (downstream).

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_mul_seq.sv | 56 +++++
 rtl/alu_pipe.sv | 182 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the pipelined ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_INC  = 4'b0010;
   localparam logic [3:0] OP_DEC  = 4'b0011;
   localparam logic [3:0] OP_SHL  = 4'b0100;
   localparam logic [3:0] OP_SHR  = 4'b0101;
   localparam logic [3:0] OP_ASR  = 4'b0110;
   localparam logic [3:0] OP_MUL  = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_NOT  = 4'b1011;
   localparam logic [3:0] OP_NAND = 4'b1100;
   localparam logic [3:0] OP_NOR  = 4'b1101;
   localparam logic [3:0] OP_XNOR = 4'b1110;
   localparam logic [3:0] OP_PASS = 4'b1111;

   localparam int FLG_Z = 0;
   localparam int FLG_C = 1;
   localparam int FLG_V = 2;
   localparam int FLG_N = 3;

   typedef enum logic {IDLE, MUL} state_t;

   function automatic logic [3:0] pack_flags(input logic n, input logic v,
                                             input logic c, input logic z);
      logic [3:0] f;
      f        = '0;
      f[FLG_N] = n;
      f[FLG_V] = v;
      f[FLG_C] = c;
      f[FLG_Z] = z;
      return f;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, N cycles,
// done pulses for one cycle once the 2N-bit product is final.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N);

   logic [2*N-1:0] mcand;
   logic [N-1:0]   mplier;
   logic [CW-1:0]  cnt;
   logic           busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            mcand   <= {{N{1'b0}}, a};
            mplier  <= b;
            product <= '0;
            cnt     <= CW'(N-1);
            busy    <= 1'b1;
         end else if (busy) begin
            // product doubles as the accumulator; it is final when done rises
            if (mplier[0])
               product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               cnt <= cnt - CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// N-bit ALU with registered result, valid/ready on both sides and status flags.
// ALU_PIPE_MUL_EN adds the multi-cycle multiplier; without it opcode 0111 flags err.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [M-1:0] instruction,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] alu_out,
   output logic [3:0]   flags,
   output logic         err
);

   state_t       state;
   logic         accept;
   logic         load_single;
   logic         load_mul;
   logic [N-1:0] mul_res;
   logic [3:0]   mul_flags;
   logic [3:0]   op;

   logic [N:0]   ext;
   logic [N-1:0] res;
   logic         c;
   logic         v;
   logic         e;
   logic [3:0]   flags_c;

   assign op       = instruction;
   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      ext = '0;
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      e   = 1'b0;
      case (op)
         OP_ADD: begin
            ext = {1'b0, a} + {1'b0, b};
            res = ext[N-1:0];
            c   = ext[N];
            v   = (a[N-1] == b[N-1]) && (res[N-1] != a[N-1]);
         end
         OP_SUB: begin
            ext = {1'b0, a} - {1'b0, b};
            res = ext[N-1:0];
            c   = ext[N];
            v   = (a[N-1] != b[N-1]) && (res[N-1] != a[N-1]);
         end
         OP_INC: begin
            ext = {1'b0, a} + (N+1)'(1);
            res = ext[N-1:0];
            c   = ext[N];
            v   = !a[N-1] && res[N-1];
         end
         OP_DEC: begin
            ext = {1'b0, a} - (N+1)'(1);
            res = ext[N-1:0];
            c   = ext[N];
            v   = a[N-1] && !res[N-1];
         end
         OP_SHL: begin
            ext = {a, 1'b0};
            res = ext[N-1:0];
            c   = ext[N];
            v   = a[N-1] ^ a[N-2];
         end
         OP_SHR: begin
            res = {1'b0, a[N-1:1]};
            c   = a[0];
         end
         OP_ASR: begin
            res = {a[N-1], a[N-1:1]};
            c   = a[0];
         end
         OP_MUL: begin
`ifndef ALU_PIPE_MUL_EN
            e = 1'b1;
`endif
         end
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_NOT:  res = ~a;
         OP_NAND: res = ~(a & b);
         OP_NOR:  res = ~(a | b);
         OP_XNOR: res = ~(a ^ b);
         OP_PASS: res = a;
         default: res = '0;
      endcase
   end

   assign flags_c = pack_flags(res[N-1], v, c, res == '0);

`ifdef ALU_PIPE_MUL_EN
   state_t         state_nx;
   logic           mul_start;
   logic           mul_done;
   logic [2*N-1:0] product;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      mul_start = 1'b0;
      case (state)
         IDLE: begin
            if (accept && op == OP_MUL) begin
               state_nx  = MUL;
               mul_start = 1'b1;
            end
         end
         MUL: begin
            if (mul_done)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   alu_mul_seq #(.N(N)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (product)
   );

   assign load_single = accept && (op != OP_MUL);
   assign load_mul    = mul_done;
   assign mul_res     = product[N-1:0];
   assign mul_flags   = pack_flags(product[N-1], 1'b0, |product[2*N-1:N],
                                   product[N-1:0] == '0);
`else
   assign state       = IDLE;
   assign load_single = accept;
   assign load_mul    = 1'b0;
   assign mul_res     = '0;
   assign mul_flags   = '0;
`endif

   // A new result may overwrite one being handed off in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         alu_out   <= '0;
         flags     <= '0;
         err       <= 1'b0;
      end else if (load_single) begin
         out_valid <= 1'b1;
         alu_out   <= res;
         flags     <= flags_c;
         err       <= e;
      end else if (load_mul) begin
         out_valid <= 1'b1;
         alu_out   <= mul_res;
         flags     <= mul_flags;
         err       <= 1'b0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (N=8): scoreboard of expected results pushed on
// accept and popped on each output handshake, plus directed spot checks.
module tb_alu_pipe;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] instruction;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] alu_out;
   logic [3:0] flags;
   logic       err;

   int          total = 0;
   int          bad   = 0;
   logic [12:0] q[$];
   bit          acc_seen;
   int          w;
   int          n;
   int          busy;
   logic        seen;
   logic [7:0]  bnd_a [8];
   logic [7:0]  bnd_b [8];
   logic [3:0]  bnd_op[8];

   always #5 clk = ~clk;

   alu_pipe #(.N(8), .M(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .instruction (instruction),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_out     (alu_out),
      .flags       (flags),
      .err         (err)
   );

   // Returns {err, neg, ovf, carry, zero, result}.
   function automatic logic [12:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic [3:0] op);
      int         ux, uy, sx, sy, r;
      logic       c, v, e;
      logic [7:0] res;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      r = 0; c = 1'b0; v = 1'b0; e = 1'b0;
      case (op)
         4'h0: begin r = ux + uy; c = (r > 255); v = (sx + sy > 127) || (sx + sy < -128); end
         4'h1: begin r = ux - uy; c = (ux < uy); v = (sx - sy > 127) || (sx - sy < -128); end
         4'h2: begin r = ux + 1; c = (r > 255); v = (sx + 1 > 127); end
         4'h3: begin r = ux - 1; c = (ux == 0); v = (sx - 1 < -128); end
         4'h4: begin r = ux * 2; c = x[7]; v = (x[7] != x[6]); end
         4'h5: begin r = ux / 2; c = x[0]; end
         4'h6: begin r = sx >>> 1; c = x[0]; end
         4'h7: begin
`ifdef ALU_PIPE_MUL_EN
            r = ux * uy; c = (r > 255);
`else
            e = 1'b1;
`endif
         end
         4'h8: r = {24'd0, x & y};
         4'h9: r = {24'd0, x | y};
         4'hA: r = {24'd0, x ^ y};
         4'hB: r = {24'd0, ~x};
         4'hC: r = {24'd0, ~(x & y)};
         4'hD: r = {24'd0, ~(x | y)};
         4'hE: r = {24'd0, ~(x ^ y)};
         default: r = {24'd0, x};
      endcase
      res = r[7:0];
      return {e, res[7], v, c, res == 8'h00, res};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, then step to just past the edge.
   task automatic cyc();
      logic [12:0] exp;
      @(negedge clk);
      acc_seen = 1'b0;
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            exp = (q.size() > 0) ? q.pop_front() : 13'bx;
            chk("result", {err, flags, alu_out}, exp);
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, instruction));
            acc_seen = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] xa, input logic [7:0] xb,
                       input logic [3:0] op, output int waited);
      a = xa; b = xb; instruction = op; in_valid = 1'b1;
      waited = 0;
      do begin
         cyc();
         waited++;
      end while (!acc_seen && waited < 40);
      in_valid = 1'b0;
      chk("accepted", acc_seen, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && out_valid; i++) cyc();
      chk("drained", out_valid, 0);
   endtask

   task automatic wait_out(output int cycles, output int stalled);
      cycles = 0; stalled = 0;
      while (out_valid !== 1'b1 && cycles < 30) begin
         if (in_ready === 1'b0) stalled++;
         a = ~a; b = ~b; instruction = OP_AND;
         cyc();
         cycles++;
      end
   endtask

   initial begin
      bnd_a  = '{8'h40, 8'h81, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01, 8'hC0};
      bnd_b  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h80, 8'h00};
      bnd_op = '{OP_SHL, OP_ASR, OP_DEC, OP_INC, OP_SUB, OP_ADD, OP_SHR, OP_SHL};

      rst = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h02; instruction = OP_ADD;
      out_ready = 1'b1;
      cyc(); cyc();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_out", alu_out, 0);
      chk("rst_flags", flags, 0);
      chk("rst_err", err, 0);
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_in_ready", in_ready, 1);

      send(8'hFF, 8'h01, OP_ADD, w);
      chk("add_latency", out_valid, 1);
      chk("add_ff_01", alu_out, 8'h00);
      chk("add_ff_01_flags", flags, 4'b0011);
      send(8'h7F, 8'h01, OP_ADD, w);
      chk("back_to_back", w, 1);
      chk("add_7f_01", alu_out, 8'h80);
      chk("add_7f_01_flags", flags, 4'b1100);
      send(8'h03, 8'h05, OP_SUB, w);
      chk("sub_03_05", alu_out, 8'hFE);
      chk("sub_03_05_flags", flags, 4'b1010);
      send(8'hA5, 8'hA5, OP_XOR, w);
      chk("xor_a5", alu_out, 8'h00);
      chk("xor_a5_flags", flags, 4'b0001);

      for (int i = 0; i < 8; i++) send(bnd_a[i], bnd_b[i], bnd_op[i], w);
      for (int op = 0; op < 16; op++)
         for (int k = 0; k < 3; k++)
            send(8'($urandom_range(255)), 8'($urandom_range(255)), 4'(op), w);
      drain();

      out_ready = 1'b0;
      send(8'h01, 8'h02, OP_ADD, w);
      chk("bp_first", alu_out, 8'h03);
      chk("bp_in_ready", in_ready, 0);
      a = 8'h10; b = 8'h20; instruction = OP_ADD; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_no_accept", acc_seen, 0);
         chk("bp_hold", alu_out, 8'h03);
      end
      out_ready = 1'b1;
      cyc();
      chk("bp_release_accept", acc_seen, 1);
      in_valid = 1'b0;
      chk("bp_second", alu_out, 8'h30);
      drain();

`ifdef ALU_PIPE_MUL_EN
      send(8'h0F, 8'h11, OP_MUL, w);
      wait_out(n, busy);
      chk("mul_latency", n, 9);
      chk("mul_busy", busy, 9);
      chk("mul_0f_11", alu_out, 8'hFF);
      chk("mul_0f_11_flags", flags, 4'b1000);
      send(8'h10, 8'h10, OP_MUL, w);
      wait_out(n, busy);
      chk("mul_10_10", alu_out, 8'h00);
      chk("mul_10_10_flags", flags, 4'b0011);
      drain();
      send(8'h03, 8'h04, OP_MUL, w);
      cyc(); cyc(); cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mul_rst_out_valid", out_valid, 0);
      chk("mul_rst_idle", in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         seen = seen | out_valid;
      end
      chk("mul_rst_no_result", seen, 0);
`else
      send(8'h03, 8'h04, OP_MUL, w);
      chk("mul_off_valid", out_valid, 1);
      chk("mul_off_out", alu_out, 8'h00);
      chk("mul_off_flags", flags, 4'b0001);
      chk("mul_off_err", err, 1);
      send(8'h03, 8'h04, OP_ADD, w);
      chk("err_clears", err, 0);
      drain();
`endif

      out_ready = 1'b0;
      send(8'h05, 8'h06, OP_ADD, w);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      out_ready = 1'b1;
      chk("rst_drops_held", out_valid, 0);
      chk("rst_clears_out", alu_out, 8'h00);

      drain();
      chk("sb_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
